// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dds_pkg
//  Description : Shared definitions for the DDS frequency-sweep controller:
//                sweep FSM state encoding and default datapath widths.
//                The DDS_SWEEP_TRIANGLE_EN macro (see dds_sweep_ctrl) decides
//                whether the DOWN state is ever entered.
//  Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

    // Default widths for tuning word, phase offset and dwell counter
    localparam int c_FTW_W   = 32;
    localparam int c_PHASE_W = 11;
    localparam int c_DWELL_W = 16;

    // Sweep FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dds_state_e;

endpackage : dds_pkg
`default_nettype wire

// File: rtl/dds_dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dds_dwell_timer
//  Description : Dwell counter for the sweep controller. Loads a hold count,
//                decrements once per cycle down to zero, and flags zero.
//  Ports       : clk      - clock, rising edge
//                rst_n    - synchronous active-low reset (count -> 0)
//                load     - load load_val this cycle (wins over decrement)
//                load_val - value to load
//                zero     - count is currently zero
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int DWELL_W = c_DWELL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               zero
);

    logic [DWELL_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule : dds_dwell_timer
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dds_sweep_ctrl
//  Description : Frequency-sweep controller for a DDS core. Steps the tuning
//                word K from f_start to f_stop in f_step increments, holding
//                each value for dwell+1 cycles. Single-shot or continuous.
//                Build option DDS_SWEEP_TRIANGLE_EN: continuous mode sweeps
//                up then down (triangle); without it, continuous mode
//                restarts from f_start (sawtooth) and DOWN is never used.
//  Ports       : clk, rst_n            - clock / synchronous active-low reset
//                start, stop           - one-cycle sweep / abort requests
//                mode                  - 0 single sweep, 1 continuous
//                f_start/f_stop/f_step - sweep bounds and increment
//                dwell                 - extra hold cycles per frequency
//                p_offset              - phase offset passed downstream
//                K, P                  - registered tuning word / phase
//                busy                  - sweep active
//                done, cfg_err         - one-cycle status pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FTW_W   = c_FTW_W,
    parameter int PHASE_W = c_PHASE_W,
    parameter int DWELL_W = c_DWELL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [FTW_W-1:0]   f_start,
    input  logic [FTW_W-1:0]   f_stop,
    input  logic [FTW_W-1:0]   f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [PHASE_W-1:0] p_offset,
    output logic [FTW_W-1:0]   K,
    output logic [PHASE_W-1:0] P,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    dds_state_e         r_state, w_state_nxt;

    logic [FTW_W-1:0]   r_k, w_k_nxt;
    logic [PHASE_W-1:0] r_p, w_p_nxt;
    logic               r_done, w_done_nxt;
    logic               r_cfg_err, w_cfg_err_nxt;

    // Sweep configuration captured on the accepting start edge
    logic [FTW_W-1:0]   r_f_start, r_f_stop, r_f_step;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_mode;

    logic               w_cfg_ok;
    logic               w_capture;
    logic               w_tmr_load;
    logic [DWELL_W-1:0] w_tmr_val;
    logic               w_tmr_zero;

    // Upward step, one bit wider so a step past the top never wraps
    logic [FTW_W:0]     w_sum;
    logic [FTW_W-1:0]   w_k_up;

    assign w_cfg_ok = (f_step != '0) && (f_stop >= f_start);

    assign w_sum  = {1'b0, r_k} + {1'b0, r_f_step};
    assign w_k_up = (w_sum > {1'b0, r_f_stop}) ? r_f_stop : w_sum[FTW_W-1:0];

`ifdef DDS_SWEEP_TRIANGLE_EN
    // Downward step; a borrow out of the top bit means K < f_step
    logic [FTW_W:0]     w_diff;
    logic [FTW_W-1:0]   w_k_dn;

    assign w_diff = {1'b0, r_k} - {1'b0, r_f_step};
    assign w_k_dn = (w_diff[FTW_W] || (w_diff[FTW_W-1:0] < r_f_start))
                    ? r_f_start : w_diff[FTW_W-1:0];
`endif

    dds_dwell_timer #(
        .DWELL_W  (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .zero     (w_tmr_zero)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_p       <= '0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_p       <= w_p_nxt;
            r_done    <= w_done_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_f_start <= '0;
            r_f_stop  <= '0;
            r_f_step  <= '0;
            r_dwell   <= '0;
            r_mode    <= 1'b0;
        end else if (w_capture) begin
            r_f_start <= f_start;
            r_f_stop  <= f_stop;
            r_f_step  <= f_step;
            r_dwell   <= dwell;
            r_mode    <= mode;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_p_nxt       = r_p;
        w_done_nxt    = 1'b0;
        w_cfg_err_nxt = 1'b0;
        w_capture     = 1'b0;
        w_tmr_load    = 1'b0;
        w_tmr_val     = r_dwell;

        unique case (r_state)
            IDLE: begin
                // start together with stop is a no-op, not a config error
                if (start && !stop) begin
                    if (w_cfg_ok) begin
                        w_capture   = 1'b1;
                        w_state_nxt = UP;
                        w_k_nxt     = f_start;
                        w_p_nxt     = p_offset;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = dwell;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end
            end

            UP: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    if (r_k != r_f_stop) begin
                        w_k_nxt = w_k_up;
                    end else if (!r_mode) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
`ifdef DDS_SWEEP_TRIANGLE_EN
                        // Turn around: first downward step happens now
                        w_state_nxt = DOWN;
                        w_k_nxt     = w_k_dn;
`else
                        w_k_nxt     = r_f_start;
`endif
                    end
                end
            end

`ifdef DDS_SWEEP_TRIANGLE_EN
            DOWN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    if (r_k != r_f_start) begin
                        w_k_nxt = w_k_dn;
                    end else begin
                        w_state_nxt = UP;
                        w_k_nxt     = w_k_up;
                    end
                end
            end
`endif

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign K       = r_k;
    assign P       = r_p;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign cfg_err = r_cfg_err;

endmodule : dds_sweep_ctrl
`default_nettype wire

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter FTW_W, default 32: tuning-word width.
REQ-002 SHALL have parameter PHASE_W, default 11: phase-offset width.
REQ-003 SHALL have parameter DWELL_W, default 16: dwell-counter width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle sweep request.
REQ-007 SHALL have port stop, input, 1: one-cycle abort request.
REQ-008 SHALL have port mode, input, 1: 0 = single sweep, 1 = continuous.
REQ-009 SHALL have ports f_start, f_stop and f_step, input, FTW_W each: sweep bounds and increment.
REQ-010 SHALL have port dwell, input, DWELL_W: extra hold cycles per frequency.
REQ-011 SHALL have port p_offset, input, PHASE_W: phase offset passed downstream.
REQ-012 SHALL have port K, output, FTW_W: registered tuning word to the DDS core.
REQ-013 SHALL have port P, output, PHASE_W: registered phase offset to the DDS core.
REQ-014 SHALL have ports busy, done and cfg_err, output, 1 each: busy = sweep active; done and cfg_err = one-cycle pulses.

Function
REQ-015 SHALL implement an FSM with exactly three states: IDLE, UP, DOWN.
REQ-016 SHALL, in IDLE on start with f_step != 0 and f_stop >= f_start, register the sweep inputs on that edge, and from the next cycle drive K = f_start, P = p_offset, busy = 1, load the dwell counter with dwell, and enter UP.
REQ-017 SHALL, in IDLE on start with f_step == 0 or f_stop < f_start, pulse cfg_err for one cycle, remain in IDLE, and leave K, P and busy unchanged.
REQ-018 SHALL hold each K value for exactly dwell+1 cycles; the dwell counter decrements each cycle, and the step action occurs at the edge where the counter equals 0, reloading it with dwell.
REQ-019 SHALL, in UP at step time with K != f_stop, set K = min(K + f_step, f_stop), computed at FTW_W+1 bits so that K never wraps.
REQ-020 SHALL, in DOWN at step time with K != f_start, set K = max(K - f_step, f_start), computed at FTW_W+1 bits so that K never underflows.
REQ-021 SHALL, in UP at step time with K == f_stop and mode = 0, go to IDLE, drop busy, and pulse done for one cycle, with K holding f_stop.
REQ-022 SHALL, on stop in UP or DOWN, go to IDLE at the next edge with busy = 0, K held, and no done pulse; stop SHALL win over a coincident step.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL, in IDLE when start and stop coincide, remain in IDLE and raise no pulses.
REQ-025 SHALL treat f_start == f_stop as valid: one dwell+1-cycle hold, then done (mode = 0).
REQ-026 SHALL never let the mid-sweep inputs (after the registering edge) affect K, P or state; only the registered copies are used.

Reset
REQ-027 SHALL, while rst_n = 0 at a clock edge, force state = IDLE, K = 0, P = 0, dwell counter = 0, and busy, done and cfg_err = 0, including mid-sweep.
REQ-028 SHALL require a start to be applied after reset release before any sweep begins.

Configuration
REQ-029 SHALL provide the macro DDS_SWEEP_TRIANGLE_EN.
REQ-030 SHALL, with DDS_SWEEP_TRIANGLE_EN defined and mode = 1, behave as follows: at f_stop in UP, enter DOWN; at f_start in DOWN, enter UP; both transitions apply the step rule of the new direction.
REQ-031 SHALL, without DDS_SWEEP_TRIANGLE_EN and with mode = 1, behave as follows: at f_stop in UP, set K = f_start and stay in UP; the DOWN state and subtractor are absent.

Structure
REQ-032 SHALL place the state encoding and the default widths (FTW_W, PHASE_W, DWELL_W) in shared package dds_pkg.
REQ-033 SHALL implement the dwell counter (load, decrement, zero flag) as sub-module dds_dwell_timer.

Verification
REQ-034 SHALL cover the single sweep: f_start = 100, f_stop = 130, f_step = 10, dwell = 2, mode = 0 -> K = 100, 110, 120, 130, each for 3 cycles; busy for 12 cycles; done pulses once.
REQ-035 SHALL cover clamping: f_start = 0, f_stop = 25, f_step = 10, dwell = 0 -> K = 0, 10, 20, 25, then done.
REQ-036 SHALL cover the overflow guard: f_start = 0xFFFF_FFF0, f_stop = 0xFFFF_FFFF, f_step = 0x20, dwell = 0 -> K = 0xFFFF_FFF0, then 0xFFFF_FFFF, with no wrap.
REQ-037 SHALL cover continuous mode: 100/130/10, dwell = 0, mode = 1 -> with the macro, K = 100, 110, 120, 130, 120, 110, 100, 110, ...; without it, K = 100, 110, 120, 130, 100, 110, ...
REQ-038 SHALL cover abort and reset: stop at K = 110 -> busy = 0 next cycle, K = 110 held, no done; rst_n = 0 mid-sweep -> K = 0 and state = IDLE after one edge.
REQ-039 SHALL cover invalid configuration: f_stop = 50 with f_start = 100, or f_step = 0 -> one-cycle cfg_err pulse, busy stays 0, K unchanged.
